// File: rtl/deserializer_lanes.sv
// Collects LANES-bit beats into DATA_O_W-bit words, MSB- or LSB-first.
// flush_i closes a partial word early and tags it with its valid-bit count.
module deserializer_lanes #(
    parameter int DATA_O_W  = 16,
    parameter int LANES     = 1,
    parameter bit MSB_FIRST = 1'b1,
    localparam int BEATS = DATA_O_W / LANES,
    localparam int MOD_W = $clog2(DATA_O_W + 1),
    localparam int CNT_W = $clog2(BEATS + 1)
) (
    input  logic                clk_i,
    input  logic                srst_i,
    input  logic [LANES-1:0]    data_i,
    input  logic                data_val_i,
    input  logic                flush_i,
    output logic [DATA_O_W-1:0] deser_data_o,
    output logic [MOD_W-1:0]    deser_data_mod_o,
    output logic                deser_data_val_o
);

    // Handshake: data_val_i qualifies data_i for one cycle, there is no ready;
    // deser_data_val_o is a one-cycle strobe and the consumer must always accept it.

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_FILLING = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_O_W-1:0] sr_q, sr_d;
    logic [DATA_O_W-1:0] data_q, data_d;
    logic [MOD_W-1:0]    mod_q, mod_d;
    logic                val_q, val_d;

    logic [DATA_O_W-1:0] word_in;
    logic [CNT_W-1:0]    cnt_in;
    logic                emit;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= ST_EMPTY;
            cnt_q   <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            mod_q   <= '0;
            val_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            mod_q   <= mod_d;
            val_q   <= val_d;
        end
    end

    // Each beat is written straight into its final slot, so a partial word is
    // already aligned when flushed and no post-shift is needed.
    always_comb begin
        word_in = sr_q;
        for (int b = 0; b < BEATS; b++) begin
            if (data_val_i && (cnt_q == CNT_W'(b))) begin
                if (MSB_FIRST) begin
                    word_in[DATA_O_W-1-b*LANES -: LANES] = data_i;
                end else begin
                    word_in[b*LANES +: LANES] = data_i;
                end
            end
        end
        cnt_in = cnt_q + CNT_W'(data_val_i);
        emit   = (cnt_in == CNT_W'(BEATS)) ||
                 (flush_i && ((state_q == ST_FILLING) || data_val_i));

        state_d = state_q;
        cnt_d   = cnt_in;
        sr_d    = word_in;
        if (emit) begin
            state_d = ST_EMPTY;
            cnt_d   = '0;
            sr_d    = '0;
        end else if (cnt_in != '0) begin
            state_d = ST_FILLING;
        end
    end

    always_comb begin
        val_d  = emit;
        data_d = data_q;
        mod_d  = mod_q;
        if (emit) begin
            data_d = word_in;
            mod_d  = MOD_W'(cnt_in) * MOD_W'(LANES);
        end
    end

    assign deser_data_o     = data_q;
    assign deser_data_mod_o = mod_q;
    assign deser_data_val_o = val_q;

endmodule

// File: tb/tb_deserializer_lanes.sv
// Bench for deserializer_lanes: four instances (1/4 lanes x MSB/LSB first) checked
// against a bit-serial reference model and an expected-word queue.
module tb_deserializer_lanes;

    logic        clk = 1'b0;
    logic        srst;
    logic [3:0]  d_r    [4];
    logic        v_r    [4];
    logic        f_r    [4];
    logic [15:0] o_data [4];
    logic [4:0]  o_mod  [4];
    logic        o_val  [4];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic rst_seen = 1'b0;

    // Entry layout: {instance[22:21], mod[20:16], word[15:0]}
    logic [22:0] exp_q[$];
    logic [15:0] m_word    [4];
    int          m_n       [4];
    int          strobes   [4];
    int          last_cyc  [4];
    int          prev_cyc  [4];
    logic [15:0] last_word [4];
    logic [4:0]  last_mod  [4];

    always #5 clk = ~clk;
    always @(posedge clk) rst_seen <= srst;

    deserializer_lanes #(.DATA_O_W(16), .LANES(1), .MSB_FIRST(1'b1)) u_l1_msb (
        .clk_i(clk), .srst_i(srst), .data_i(d_r[0][0]), .data_val_i(v_r[0]), .flush_i(f_r[0]),
        .deser_data_o(o_data[0]), .deser_data_mod_o(o_mod[0]), .deser_data_val_o(o_val[0]));
    deserializer_lanes #(.DATA_O_W(16), .LANES(1), .MSB_FIRST(1'b0)) u_l1_lsb (
        .clk_i(clk), .srst_i(srst), .data_i(d_r[1][0]), .data_val_i(v_r[1]), .flush_i(f_r[1]),
        .deser_data_o(o_data[1]), .deser_data_mod_o(o_mod[1]), .deser_data_val_o(o_val[1]));
    deserializer_lanes #(.DATA_O_W(16), .LANES(4), .MSB_FIRST(1'b1)) u_l4_msb (
        .clk_i(clk), .srst_i(srst), .data_i(d_r[2]), .data_val_i(v_r[2]), .flush_i(f_r[2]),
        .deser_data_o(o_data[2]), .deser_data_mod_o(o_mod[2]), .deser_data_val_o(o_val[2]));
    deserializer_lanes #(.DATA_O_W(16), .LANES(4), .MSB_FIRST(1'b0)) u_l4_lsb (
        .clk_i(clk), .srst_i(srst), .data_i(d_r[3]), .data_val_i(v_r[3]), .flush_i(f_r[3]),
        .deser_data_o(o_data[3]), .deser_data_mod_o(o_mod[3]), .deser_data_val_o(o_val[3]));

    function automatic int lanes_of(input int k);
        return (k >= 2) ? 4 : 1;
    endfunction

    function automatic bit msb_of(input int k);
        return (k % 2) == 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle on instance k and advance the bit-serial model.
    task automatic step(input int k, input logic [3:0] d, input logic v, input logic f);
        bit b;
        d_r[k] = d;
        v_r[k] = v;
        f_r[k] = f;
        if (v) begin
            for (int j = 0; j < lanes_of(k); j++) begin
                b = msb_of(k) ? d[lanes_of(k)-1-j] : d[j];
                if (msb_of(k)) m_word[k][15-m_n[k]] = b;
                else           m_word[k][m_n[k]]    = b;
                m_n[k]++;
            end
        end
        if (m_n[k] == 16 || (f && m_n[k] > 0)) begin
            exp_q.push_back({2'(k), 5'(m_n[k]), m_word[k]});
            m_n[k]    = 0;
            m_word[k] = '0;
        end
        @(negedge clk);
        d_r[k] = '0;
        v_r[k] = 1'b0;
        f_r[k] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        int idx;
        cyc++;
        for (int k = 0; k < 4; k++) begin
            if (rst_seen) begin
                check($sformatf("reset_val%0d", k), 32'(o_val[k]), 32'd0);
                check($sformatf("reset_data%0d", k), 32'(o_data[k]), 32'd0);
                check($sformatf("reset_mod%0d", k), 32'(o_mod[k]), 32'd0);
                last_word[k] = '0;
                last_mod[k]  = '0;
            end else if (o_val[k] === 1'b1) begin
                idx = -1;
                for (int i = 0; i < exp_q.size(); i++)
                    if (idx < 0 && exp_q[i][22:21] == 2'(k)) idx = i;
                strobes[k]++;
                prev_cyc[k] = last_cyc[k];
                last_cyc[k] = cyc;
                total++;
                assert (idx >= 0) else begin
                    bad++;
                    $error("FAIL unexpected_strobe%0d observed=%0h expected=none", k, o_data[k]);
                end
                if (idx >= 0) begin
                    check($sformatf("word%0d", k), {11'd0, o_mod[k], o_data[k]},
                          {11'd0, exp_q[idx][20:0]});
                    last_word[k] = exp_q[idx][15:0];
                    last_mod[k]  = exp_q[idx][20:16];
                    exp_q.delete(idx);
                end
            end else begin
                check($sformatf("hold%0d", k), {11'd0, o_mod[k], o_data[k]},
                      {11'd0, last_mod[k], last_word[k]});
            end
        end
    end

    initial begin
        logic [15:0] w;
        logic [4:0]  bits;
        int          s0;
        srst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d_r[k] = '0; v_r[k] = 1'b0; f_r[k] = 1'b0;
            m_word[k] = '0; m_n[k] = 0; strobes[k] = 0;
            last_cyc[k] = 0; prev_cyc[k] = 0;
            last_word[k] = '0; last_mod[k] = '0;
        end
        idle(3);
        check("init_val", 32'(o_val[0]), 32'd0);
        check("init_data", 32'(o_data[0]), 32'd0);
        srst = 1'b0;
        idle(1);

        // Full word, contiguous beats, MSB first
        w = 16'hA5C3;
        for (int i = 0; i < 16; i++) step(0, {3'b0, w[15-i]}, 1'b1, 1'b0);
        check("t1_val", 32'(o_val[0]), 32'd1);
        check("t1_data", 32'(o_data[0]), 32'hA5C3);
        check("t1_mod", 32'(o_mod[0]), 32'd16);
        idle(1);

        // Same word with random idle gaps
        s0 = strobes[0];
        for (int i = 0; i < 16; i++) begin
            idle($urandom_range(0, 3));
            step(0, {3'b0, w[15-i]}, 1'b1, 1'b0);
        end
        check("t2_data", 32'(o_data[0]), 32'hA5C3);
        idle(2);
        check("t2_strobes", 32'(strobes[0] - s0), 32'd1);

        // Partial words flushed on both bit orders
        bits = 5'b10110;
        for (int i = 0; i < 5; i++) step(0, {3'b0, bits[4-i]}, 1'b1, 1'b0);
        step(0, 4'd0, 1'b0, 1'b1);
        check("t3_msb_data", 32'(o_data[0]), 32'hB000);
        check("t3_msb_mod", 32'(o_mod[0]), 32'd5);
        for (int i = 0; i < 5; i++) step(1, {3'b0, bits[4-i]}, 1'b1, 1'b0);
        step(1, 4'd0, 1'b0, 1'b1);
        check("t3_lsb_data", 32'(o_data[1]), 32'h000D);
        check("t3_lsb_mod", 32'(o_mod[1]), 32'd5);
        idle(1);

        // Flush with the final beat, then flush while empty
        s0 = strobes[0];
        for (int i = 0; i < 15; i++) step(0, 4'($urandom_range(0, 1)), 1'b1, 1'b0);
        step(0, 4'd1, 1'b1, 1'b1);
        check("t4_val", 32'(o_val[0]), 32'd1);
        check("t4_mod", 32'(o_mod[0]), 32'd16);
        idle(2);
        check("t4_one_strobe", 32'(strobes[0] - s0), 32'd1);
        step(0, 4'd0, 1'b0, 1'b1);
        check("t4_empty_flush_val", 32'(o_val[0]), 32'd0);
        idle(1);
        check("t4_empty_flush_cnt", 32'(strobes[0] - s0), 32'd1);

        // Four lanes, back-to-back words
        step(2, 4'hA, 1'b1, 1'b0); step(2, 4'h5, 1'b1, 1'b0);
        step(2, 4'hC, 1'b1, 1'b0); step(2, 4'h3, 1'b1, 1'b0);
        check("t5_w0", 32'(o_data[2]), 32'hA5C3);
        step(2, 4'h1, 1'b1, 1'b0); step(2, 4'h2, 1'b1, 1'b0);
        step(2, 4'h3, 1'b1, 1'b0); step(2, 4'h4, 1'b1, 1'b0);
        check("t5_w1", 32'(o_data[2]), 32'h1234);
        check("t5_w1_val", 32'(o_val[2]), 32'd1);
        idle(1);
        check("t5_spacing", 32'(last_cyc[2] - prev_cyc[2]), 32'd4);

        // Reset in the middle of a partial word discards it
        for (int i = 0; i < 7; i++) step(0, 4'($urandom_range(0, 1)), 1'b1, 1'b0);
        srst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            m_n[k] = 0;
            m_word[k] = '0;
        end
        idle(1);
        check("t6_rst_val", 32'(o_val[0]), 32'd0);
        check("t6_rst_data", 32'(o_data[0]), 32'd0);
        idle(1);
        srst = 1'b0;
        idle(1);
        check("t6_after_data", 32'(o_data[0]), 32'd0);
        check("t6_after_mod", 32'(o_mod[0]), 32'd0);
        for (int i = 0; i < 16; i++) step(0, 4'd1, 1'b1, 1'b0);
        check("t6_data", 32'(o_data[0]), 32'hFFFF);
        check("t6_mod", 32'(o_mod[0]), 32'd16);

        // Random traffic on all instances
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3), 4'($urandom),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end
        idle(3);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
